edge_stat_sampler: RTL and testbench

EDGE_STAT_SAMPLER -- requirements
Module: edge_stat_sampler

---
 rtl/edge_stat_sampler.sv | 169 ++++++++++++++++
 tb/tb_edge_stat_sampler.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_stat_sampler.sv
// edge_stat_sampler
//   Counts rising edges on a bank of asynchronous, idle-high serial lines.
//   Each channel keeps two counters. The raw counter counts every low-to-high
//   transition of the synchronized line. The qualified counter counts only
//   episodes where the line then stays high for MIN_HIGH consecutive samples.
//   One channel at a time is read out through a registered mux.
//
//   Optional feature: define EDGE_STAT_SAMPLER_SATURATE_EN to make the
//   counters stop at all-ones. Without it they wrap to zero. In both builds
//   the sticky overflow flag is set.
//
// Parameters
//   CHANNELS   number of rx lines (1..16)
//   MIN_HIGH   consecutive high samples that qualify an edge (>= 2)
//   CNT_W      width of every event counter
//
// Ports
//   clock      sole clock, rising edge
//   reset      asynchronous, active-high reset
//   rx         asynchronous serial lines, idle high
//   clear      synchronous pulse; zeroes all counters and overflow flags
//   sel        channel select for readout; values >= CHANNELS read as 0
//   raw_count  raw rising-edge count of the selected channel (1-clock latency)
//   qual_count qualified-edge count of the selected channel (1-clock latency)
//   overflow   sticky overflow flag of the selected channel (1-clock latency)

module edge_stat_sampler #(
  parameter int CHANNELS = 4,
  parameter int MIN_HIGH = 256,
  parameter int CNT_W    = 12
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] rx,
  input  logic                clear,
  input  logic [3:0]          sel,
  output logic [CNT_W-1:0]    raw_count,
  output logic [CNT_W-1:0]    qual_count,
  output logic                overflow
);

  localparam int RUN_W = $clog2(MIN_HIGH + 1);
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(MIN_HIGH);
  localparam logic [RUN_W-1:0] RUN_PRE  = RUN_W'(MIN_HIGH - 1);
  localparam logic [CNT_W-1:0] CNT_ONES = '1;

  logic [CHANNELS-1:0] sync_meta;
  logic [CHANNELS-1:0] sync_s;
  logic [CHANNELS-1:0] prev;
  logic [CHANNELS-1:0] raw_det;
  logic [CHANNELS-1:0] qual_det;
  logic [CHANNELS-1:0] raw_evt;
  logic [CHANNELS-1:0] qual_evt;
  logic [RUN_W-1:0]    run      [CHANNELS];
  logic [CNT_W-1:0]    raw_cnt  [CHANNELS];
  logic [CNT_W-1:0]    qual_cnt [CHANNELS];
  logic [CHANNELS-1:0] ovf;

  logic [CNT_W-1:0]    sel_raw;
  logic [CNT_W-1:0]    sel_qual;
  logic                sel_ovf;

  // A qualified edge is the sample that moves run from MIN_HIGH-1 to
  // MIN_HIGH. Because run holds at MIN_HIGH, each high episode yields at most
  // one qualified edge.
  always_comb begin
    raw_det  = ~prev & sync_s;
    qual_det = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      qual_det[i] = sync_s[i] && (run[i] == RUN_PRE);
    end
  end

  // Reset presets the synchronizers, prev and run to the idle-high value.
  // As a result, a line that is already high when reset is released produces
  // no event until it has been seen low. Any partial run is also discarded.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_meta <= '1;
      sync_s    <= '1;
      prev      <= '1;
      raw_evt   <= '0;
      qual_evt  <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        run[i] <= RUN_MAX;
      end
    end else begin
      sync_meta <= rx;
      sync_s    <= sync_meta;
      prev      <= sync_s;
      raw_evt   <= raw_det;
      qual_evt  <= qual_det;
      for (int i = 0; i < CHANNELS; i++) begin
        if (!sync_s[i]) begin
          run[i] <= '0;
        end else if (run[i] != RUN_MAX) begin
          run[i] <= run[i] + RUN_W'(1);
        end
      end
    end
  end

  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
`ifdef EDGE_STAT_SAMPLER_SATURATE_EN
    return (v == CNT_ONES) ? v : v + CNT_W'(1);
`else
    return v + CNT_W'(1);
`endif
  endfunction

  // clear zeroes the counters and the overflow flags only. The line-tracking
  // state is left alone, so clear never invents or loses a future edge. An
  // increment that lands on the same edge as clear is dropped.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ovf <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        raw_cnt[i]  <= '0;
        qual_cnt[i] <= '0;
      end
    end else if (clear) begin
      ovf <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        raw_cnt[i]  <= '0;
        qual_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (raw_evt[i]) begin
          raw_cnt[i] <= bump(raw_cnt[i]);
        end
        if (qual_evt[i]) begin
          qual_cnt[i] <= bump(qual_cnt[i]);
        end
        if ((raw_evt[i] && (raw_cnt[i] == CNT_ONES)) ||
            (qual_evt[i] && (qual_cnt[i] == CNT_ONES))) begin
          ovf[i] <= 1'b1;
        end
      end
    end
  end

  // Out-of-range selects match no channel and read as zero.
  always_comb begin
    sel_raw  = '0;
    sel_qual = '0;
    sel_ovf  = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (sel == 4'(i)) begin
        sel_raw  = raw_cnt[i];
        sel_qual = qual_cnt[i];
        sel_ovf  = ovf[i];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      raw_count  <= '0;
      qual_count <= '0;
      overflow   <= 1'b0;
    end else begin
      raw_count  <= sel_raw;
      qual_count <= sel_qual;
      overflow   <= sel_ovf;
    end
  end

endmodule

// File: tb/tb_edge_stat_sampler.sv
module tb_edge_stat_sampler;

  localparam int CH  = 4;
  localparam int MH  = 8;
  localparam int CW  = 4;
  localparam int MAXC = (1 << CW) - 1;
`ifdef EDGE_STAT_SAMPLER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  localparam int OVF_EXP = SAT ? 15 : 1;

  logic          clock = 1'b0;
  logic          reset;
  // dut_a: default parameters
  logic [CH-1:0] rx_a;
  logic          clear_a;
  logic [3:0]    sel_a;
  logic [11:0]   raw_a;
  logic [11:0]   qual_a;
  logic          ovf_a;
  // dut_b: MIN_HIGH=8, CNT_W=4
  logic [CH-1:0] rx_b;
  logic          clear_b;
  logic [3:0]    sel_b;
  logic [CW-1:0] raw_b;
  logic [CW-1:0] qual_b;
  logic          ovf_b;

  always #5 clock = ~clock;

  edge_stat_sampler #(.CHANNELS(CH)) dut_a (
    .clock(clock), .reset(reset), .rx(rx_a), .clear(clear_a), .sel(sel_a),
    .raw_count(raw_a), .qual_count(qual_a), .overflow(ovf_a)
  );

  edge_stat_sampler #(.CHANNELS(CH), .MIN_HIGH(MH), .CNT_W(CW)) dut_b (
    .clock(clock), .reset(reset), .rx(rx_b), .clear(clear_b), .sel(sel_b),
    .raw_count(raw_b), .qual_count(qual_b), .overflow(ovf_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check3(input string name, input int ar, input int aq, input int ao,
                        input int er, input int eq, input int eo);
    checks++;
    if (ar != er || aq != eq || ao != eo) begin
      errors++;
      $display("FAIL %s: raw/qual/ovf got %0d/%0d/%0d expected %0d/%0d/%0d",
               name, ar, aq, ao, er, eq, eo);
    end
  endtask

  // Reference model for dut_b. It works on the history of the synchronized
  // line: s is rx two samples ago. A raw event is a 0->1 step of s. A
  // qualified event is the sample where the current run of ones in s reaches
  // exactly MH. Events reach the counters two edges after detection, and the
  // readout shows the counter state of the previous cycle.
  bit m_sync1 [CH];
  bit m_s     [CH];
  int m_ones  [CH];
  bit m_rp1 [CH], m_rp2 [CH], m_qp1 [CH], m_qp2 [CH];
  int m_raw [CH], m_qual [CH];
  bit m_ovf [CH];
  int m_out_raw, m_out_qual, m_out_ovf;

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_sync1[c] = 1; m_s[c] = 1; m_ones[c] = 1000;
      m_rp1[c] = 0; m_rp2[c] = 0; m_qp1[c] = 0; m_qp2[c] = 0;
      m_raw[c] = 0; m_qual[c] = 0; m_ovf[c] = 0;
    end
    m_out_raw = 0; m_out_qual = 0; m_out_ovf = 0;
  endtask

  task automatic model_inc(inout int v, inout bit ov);
    if (v == MAXC) begin
      ov = 1;
      v  = SAT ? MAXC : 0;
    end else begin
      v++;
    end
  endtask

  task automatic model_edge(input logic [CH-1:0] rxv, input bit clr, input logic [3:0] selv);
    int si;
    bit new_s;
    si = int'(selv);
    if (si < CH) begin
      m_out_raw = m_raw[si]; m_out_qual = m_qual[si]; m_out_ovf = int'(m_ovf[si]);
    end else begin
      m_out_raw = 0; m_out_qual = 0; m_out_ovf = 0;
    end
    for (int c = 0; c < CH; c++) begin
      if (clr) begin
        m_raw[c] = 0; m_qual[c] = 0; m_ovf[c] = 0;
      end else begin
        if (m_rp2[c]) model_inc(m_raw[c], m_ovf[c]);
        if (m_qp2[c]) model_inc(m_qual[c], m_ovf[c]);
      end
      m_rp2[c] = m_rp1[c];
      m_qp2[c] = m_qp1[c];
      new_s = m_sync1[c];
      m_sync1[c] = rxv[c];
      if (new_s) begin
        if (m_ones[c] < 1000) m_ones[c]++;
      end else begin
        m_ones[c] = 0;
      end
      m_rp1[c] = !m_s[c] && new_s;
      m_qp1[c] = new_s && (m_ones[c] == MH);
      m_s[c] = new_s;
    end
  endtask

  task automatic step(input logic [CH-1:0] rxv, input bit clr, input logic [3:0] selv);
    rx_b = rxv; clear_b = clr; sel_b = selv;
    @(posedge clock);
    model_edge(rxv, clr, selv);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step('1, 1'b0, sel_b);
  endtask

  task automatic drive(input int ch, input bit level, input int n);
    logic [CH-1:0] v;
    v = '1;
    v[ch] = level;
    repeat (n) step(v, 1'b0, sel_b);
  endtask

  task automatic pulses(input int ch, input int n, input int lo, input int hi);
    repeat (n) begin
      drive(ch, 1'b0, lo);
      drive(ch, 1'b1, hi);
    end
  endtask

  task automatic read_b(input string name, input int ch, input int er, input int eq, input int eo);
    step('1, 1'b0, 4'(ch));
    check3(name, int'(raw_b), int'(qual_b), int'(ovf_b), er, eq, eo);
  endtask

  typedef struct {
    int ch;
    int lo_a;
    int hi_a;
    int lo_b;
    int exp_raw;
    int exp_qual;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CH-1:0] lvl;
    logic [CH-1:0] rxv;
    logic [3:0]    selv;
    int            hold [CH];
    bit            clr;

    // pattern: low lo_a, high hi_a, low lo_b (if > 0), then idle high
    vecs[0] = '{0, 3, 10, 0, 1, 1};
    vecs[1] = '{1, 1,  3, 1, 2, 1};
    vecs[2] = '{2, 2,  7, 1, 2, 1};
    vecs[3] = '{3, 2,  8, 1, 2, 2};
    vecs[4] = '{0, 1,  1, 1, 2, 1};
    vecs[5] = '{1, 4, 12, 3, 2, 2};

    rx_a = '1; clear_a = 1'b0; sel_a = 4'd0;
    rx_b = '1; clear_b = 1'b0; sel_b = 4'd0;
    reset = 1'b0;
    #2 reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check3("reset_a", int'(raw_a), int'(qual_a), int'(ovf_a), 0, 0, 0);
    check3("reset_b", int'(raw_b), int'(qual_b), int'(ovf_b), 0, 0, 0);
    model_reset();
    reset = 1'b0;

    // idle-high lines after reset produce nothing, default parameters
    idle(300);
    for (int s = 0; s < CH; s++) begin
      sel_a = 4'(s);
      idle(1);
      check3("idle_a", int'(raw_a), int'(qual_a), int'(ovf_a), 0, 0, 0);
    end

    // MIN_HIGH=256 boundary on dut_a channel 1
    sel_a = 4'd1;
    rx_a[1] = 1'b0;
    idle(2);
    rx_a[1] = 1'b1;
    idle(258);
    check3("minhigh256_before", int'(raw_a), int'(qual_a), int'(ovf_a), 1, 0, 0);
    idle(2);
    check3("minhigh256_after", int'(raw_a), int'(qual_a), int'(ovf_a), 1, 1, 0);

    // table-driven episodes on dut_b
    for (int r = 0; r < 6; r++) begin
      step('1, 1'b1, 4'd0);
      idle(2);
      drive(vecs[r].ch, 1'b0, vecs[r].lo_a);
      drive(vecs[r].ch, 1'b1, vecs[r].hi_a);
      if (vecs[r].lo_b > 0) drive(vecs[r].ch, 1'b0, vecs[r].lo_b);
      idle(30);
      read_b("vec_sel", vecs[r].ch, vecs[r].exp_raw, vecs[r].exp_qual, 0);
      read_b("vec_other", (vecs[r].ch + 1) % CH, 0, 0, 0);
      read_b("vec_sel_range", 4 + r, 0, 0, 0);
    end

    // latency of raw and qualified counts, channel 0
    step('1, 1'b1, 4'd0);
    idle(2);
    drive(0, 1'b0, 3);
    drive(0, 1'b1, 4);
    check3("raw_latency_early", int'(raw_b), int'(qual_b), int'(ovf_b), 0, 0, 0);
    drive(0, 1'b1, 1);
    check3("raw_latency_edge", int'(raw_b), int'(qual_b), int'(ovf_b), 1, 0, 0);
    drive(0, 1'b1, 6);
    check3("qual_latency_early", int'(raw_b), int'(qual_b), int'(ovf_b), 1, 0, 0);
    drive(0, 1'b1, 1);
    check3("qual_latency_edge", int'(raw_b), int'(qual_b), int'(ovf_b), 1, 1, 0);

    // clear on the same edge as a raw increment, channel 2
    step('1, 1'b1, 4'd2);
    idle(3);
    drive(2, 1'b0, 2);
    drive(2, 1'b1, 3);
    step('1, 1'b1, 4'd2);
    step('1, 1'b0, 4'd2);
    check3("clear_vs_inc", int'(raw_b), int'(qual_b), int'(ovf_b), 0, 0, 0);
    idle(20);
    read_b("clear_vs_inc_later", 2, 0, 1, 0);
    drive(2, 1'b0, 1);
    idle(20);
    read_b("clear_next_edge", 2, 1, 2, 0);

    // counter overflow: raw only on ch3, then raw and qual on ch0
    step('1, 1'b1, 4'd3);
    pulses(3, 17, 1, 2);
    idle(20);
    read_b("ovf_raw", 3, OVF_EXP, 1, 1);
    step('1, 1'b1, 4'd0);
    pulses(0, 17, 1, 9);
    idle(20);
    read_b("ovf_raw_qual", 0, OVF_EXP, OVF_EXP, 1);
    read_b("ovf_other", 3, 0, 0, 0);
    step('1, 1'b1, 4'd0);
    read_b("ovf_cleared", 0, 0, 0, 0);

    // reset in the middle of a high run (run = 5), channel 0
    drive(0, 1'b0, 2);
    drive(0, 1'b1, 7);
    check3("pre_reset", int'(raw_b), int'(qual_b), int'(ovf_b), 1, 0, 0);
    rx_b = '1;
    reset = 1'b1;
    #1;
    check3("mid_reset", int'(raw_b), int'(qual_b), int'(ovf_b), 0, 0, 0);
    repeat (2) @(posedge clock);
    #1;
    model_reset();
    reset = 1'b0;
    idle(30);
    read_b("post_reset_idle", 0, 0, 0, 0);
    drive(0, 1'b0, 1);
    drive(0, 1'b1, 11);
    check3("post_reset_qual_early", int'(raw_b), int'(qual_b), int'(ovf_b), 1, 0, 0);
    drive(0, 1'b1, 1);
    check3("post_reset_qual", int'(raw_b), int'(qual_b), int'(ovf_b), 1, 1, 0);

    // randomized traffic against the model; the last third toggles all lines together
    lvl = '1;
    for (int c = 0; c < CH; c++) hold[c] = int'($urandom_range(1, 12));
    selv = 4'd0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int c = 0; c < CH; c++) begin
        if (hold[c] == 0) begin
          lvl[c] = ~lvl[c];
          hold[c] = int'($urandom_range(1, 12));
        end else begin
          hold[c]--;
        end
      end
      rxv = (cyc >= 2000) ? {CH{lvl[0]}} : lvl;
      clr = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 7) == 0) begin
        selv = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
      end
      step(rxv, clr, selv);
      check3("random", int'(raw_b), int'(qual_b), int'(ovf_b), m_out_raw, m_out_qual, m_out_ovf);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
